uart_tx_scheduler: RTL and testbench

Parametrised multi-channel transmit scheduler between the command generators (game-state, target-machine, operate-machine and future sources) and the UART transmit port. Each cycle it checks every enabled channel against the last byte it sent for that channel. It queues changed bytes through a round-robin arbiter into a FIFO, then presents them one at a time on the UART byte input, advancing on each UART byte-done pulse. It sits in the `uart_clk_16` domain and replaces the fixed three-source send logic.

---
 rtl/uart_tx_scheduler.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Multi-channel change-detect transmit scheduler: round-robin grants into a FIFO that feeds the UART byte port.
// Optional periodic resend of every enabled channel is compiled in when UART_TX_SCHED_REFRESH_EN is defined.
module uart_tx_scheduler #(
    parameter int         CHANNELS       = 4,
    parameter int         DEPTH          = 8,
    parameter logic [7:0] IDLE_BYTE      = 8'h00,
    parameter int         REFRESH_CYCLES = 153600,
    localparam int        CW             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int        AW             = $clog2(DEPTH),
    localparam int        LW             = AW + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CHANNELS*8-1:0] ch_data,
    input  logic [CHANNELS-1:0]   ch_en,
    input  logic                  pause,
    input  logic                  tx_done,
    output logic [7:0]            tx_bits,
    output logic                  tx_active,
    output logic [LW-1:0]         fifo_level,
    output logic [7:0]            last_sent,
    output logic [CW-1:0]         grant_ch
);

    if (CHANNELS < 1 || CHANNELS > 16 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REFRESH_CYCLES < 2) begin : g_param_check
        $error("uart_tx_scheduler: illegal parameter set");
    end

    logic [7:0]          shadow_r [CHANNELS];
    logic [7:0]          mem_r    [DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [LW-1:0]       level_r;
    logic [CW-1:0]       rr_r;
    logic [CW-1:0]       grant_ch_r;
    logic [7:0]          cur_bits_r;
    logic                cur_valid_r;
    logic [7:0]          last_sent_r;
    logic [CHANNELS-1:0] refresh_req_s;
    logic [CHANNELS-1:0] pending_s;
    logic                hi_found_s;
    logic [CW-1:0]       hi_win_s;
    logic [CW-1:0]       lo_win_s;
    logic                found_s;
    logic [CW-1:0]       win_s;
    logic [7:0]          win_byte_s;
    logic                pop_s;
    logic                can_push_s;
    logic                grant_s;

`ifdef UART_TX_SCHED_REFRESH_EN
    localparam int RW = $clog2(REFRESH_CYCLES);
    logic [RW-1:0]       refresh_cnt_r;
    logic [CHANNELS-1:0] refresh_req_r;
    logic                refresh_wrap_s;
    logic [CHANNELS-1:0] grant_mask_s;

    assign refresh_wrap_s = (refresh_cnt_r == RW'(REFRESH_CYCLES - 1));
    assign grant_mask_s   = grant_s ? (CHANNELS'(1) << win_s) : '0;
    assign refresh_req_s  = refresh_req_r;

    // Refresh timer; a wrap re-arms every enabled channel, a grant or disable clears its request
    always_ff @(posedge clock) begin
        if (reset) begin
            refresh_cnt_r <= '0;
            refresh_req_r <= '0;
        end else begin
            refresh_cnt_r <= refresh_wrap_s ? '0 : refresh_cnt_r + RW'(1);
            refresh_req_r <= (refresh_req_r & ~grant_mask_s & ch_en) | (refresh_wrap_s ? ch_en : '0);
        end
    end
`else
    assign refresh_req_s = '0;
`endif

    // Change detection against the last byte granted per channel
    always_comb begin
        pending_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pending_s[i] = ch_en[i] & ((ch_data[8*i +: 8] != shadow_r[i]) | refresh_req_s[i]);
        end
    end

    // Round-robin pick: lowest pending index at/after rr, else lowest pending overall (wrap)
    always_comb begin
        hi_found_s = 1'b0;
        hi_win_s   = '0;
        lo_win_s   = '0;
        win_byte_s = 8'h00;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            hi_found_s = hi_found_s | (pending_s[i] & (i >= int'(rr_r)));
            hi_win_s   = (pending_s[i] && (i >= int'(rr_r))) ? CW'(i) : hi_win_s;
            lo_win_s   = pending_s[i] ? CW'(i) : lo_win_s;
        end
        found_s = |pending_s;
        win_s   = hi_found_s ? hi_win_s : lo_win_s;
        for (int i = 0; i < CHANNELS; i++) begin
            win_byte_s = (int'(win_s) == i) ? ch_data[8*i +: 8] : win_byte_s;
        end
    end

    // A pop only happens with data present, so push-into-empty never pairs with a pop
    assign pop_s      = tx_done & (level_r != '0);
    assign can_push_s = (level_r < LW'(DEPTH)) | pop_s;
    assign grant_s    = ~pause & found_s & can_push_s;

    // Arbiter state and per-channel shadows
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_r       <= '0;
            grant_ch_r <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_r[i] <= 8'h00;
            end
        end else if (grant_s) begin
            rr_r       <= (int'(win_s) == CHANNELS - 1) ? '0 : win_s + CW'(1);
            grant_ch_r <= win_s;
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(win_s) == i) begin
                    shadow_r[i] <= win_byte_s;
                end
            end
        end
    end

    // FIFO storage; contents are qualified by the level, so no reset is needed
    always_ff @(posedge clock) begin
        if (grant_s) begin
            mem_r[wr_ptr_r] <= win_byte_s;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (grant_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({grant_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Output stage: the presented byte only moves on a UART byte-done pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_bits_r  <= IDLE_BYTE;
            cur_valid_r <= 1'b0;
            last_sent_r <= 8'h00;
        end else if (tx_done) begin
            if (pop_s) begin
                cur_bits_r  <= mem_r[rd_ptr_r];
                cur_valid_r <= 1'b1;
                last_sent_r <= mem_r[rd_ptr_r];
            end else begin
                cur_bits_r  <= IDLE_BYTE;
                cur_valid_r <= 1'b0;
            end
        end
    end

    assign tx_bits    = cur_bits_r;
    assign tx_active  = cur_valid_r;
    assign fifo_level = level_r;
    assign last_sent  = last_sent_r;
    assign grant_ch   = grant_ch_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_scheduler;

    localparam int         CH   = 4;
    localparam int         DP   = 4;
    localparam int         RC   = 16;
    localparam logic [7:0] IDLE = 8'h00;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ch_data;
    logic [3:0]  ch_en;
    logic        pause;
    logic        tx_done;
    logic [7:0]  tx_bits;
    logic        tx_active;
    logic [2:0]  fifo_level;
    logic [7:0]  last_sent;
    logic [1:0]  grant_ch;

    uart_tx_scheduler #(
        .CHANNELS(CH), .DEPTH(DP), .IDLE_BYTE(IDLE), .REFRESH_CYCLES(RC)
    ) dut (
        .clock(clock), .reset(reset), .ch_data(ch_data), .ch_en(ch_en),
        .pause(pause), .tx_done(tx_done), .tx_bits(tx_bits), .tx_active(tx_active),
        .fifo_level(fifo_level), .last_sent(last_sent), .grant_ch(grant_ch)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_q [$];
    logic [7:0] m_shadow [CH];
    int         m_rr;
    logic [7:0] m_cur;
    logic       m_valid;
    logic [7:0] m_last;
    int         m_gch;
    int         m_cnt;
    logic [3:0] m_req;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pend(input int c);
        return ch_en[c] && ((ch_data[8*c +: 8] != m_shadow[c]) || m_req[c]);
    endfunction

    // Advance the model by one clock using the inputs the DUT is about to sample
    task automatic model_step();
        int         found;
        int         win;
        int         pop;
        int         grant;
        logic [7:0] b;
        if (reset) begin
            m_q.delete();
            for (int c = 0; c < CH; c++) m_shadow[c] = 8'h00;
            m_rr = 0; m_cur = IDLE; m_valid = 1'b0; m_last = 8'h00; m_gch = 0;
            m_cnt = 0; m_req = 4'h0;
            return;
        end
        pop   = (tx_done && m_q.size() > 0) ? 1 : 0;
        found = 0;
        win   = 0;
        for (int k = 0; k < CH; k++) begin
            int c = (m_rr + k) % CH;
            if (found == 0 && pend(c)) begin
                found = 1;
                win   = c;
            end
        end
        grant = (!pause && found == 1 && (m_q.size() < DP || pop == 1)) ? 1 : 0;
`ifdef UART_TX_SCHED_REFRESH_EN
        begin
            logic       wrap;
            logic [3:0] mask;
            wrap  = (m_cnt == RC - 1);
            mask  = (grant == 1) ? (4'(1) << win) : 4'h0;
            m_cnt = wrap ? 0 : m_cnt + 1;
            m_req = (m_req & ~mask & ch_en) | (wrap ? ch_en : 4'h0);
        end
`endif
        if (tx_done) begin
            if (pop == 1) begin
                b = m_q.pop_front();
                m_cur = b; m_valid = 1'b1; m_last = b;
            end else begin
                m_cur = IDLE; m_valid = 1'b0;
            end
        end
        if (grant == 1) begin
            b = ch_data[8*win +: 8];
            m_q.push_back(b);
            m_shadow[win] = b;
            m_rr  = (win + 1) % CH;
            m_gch = win;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check("tx_bits",    int'(tx_bits),    int'(m_cur));
        check("tx_active",  int'(tx_active),  int'(m_valid));
        check("fifo_level", int'(fifo_level), m_q.size());
        check("last_sent",  int'(last_sent),  int'(m_last));
        check("grant_ch",   int'(grant_ch),   m_gch);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DP + 2; i++) begin
            tx_done = 1'b1; tick();
            tx_done = 1'b0; tick();
        end
    endtask

    logic [7:0] rr_exp [5];

    initial begin
        rr_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        reset = 1'b1; ch_data = 32'h0; ch_en = 4'h0; pause = 1'b0; tx_done = 1'b0;
        tick(); tick();
        check("rst_bits", int'(tx_bits), 0);
        check("rst_level", int'(fifo_level), 0);
        reset = 1'b0;

        // Reset and idle
        repeat (3) begin
            tx_done = 1'b1; tick();
            tx_done = 1'b0; tick();
        end
        check("idle_bits", int'(tx_bits), 8'h00);
        check("idle_active", int'(tx_active), 0);
        check("idle_level", int'(fifo_level), 0);

        // Round-robin: four grants on consecutive cycles, then in-order transmission
        ch_en = 4'hF; ch_data = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_level", int'(fifo_level), i + 1);
            check("rr_grant", int'(grant_ch), i);
        end
        for (int i = 0; i < 5; i++) begin
            tx_done = 1'b1; tick();
            tx_done = 1'b0;
            check("rr_bits", int'(tx_bits), int'(rr_exp[i]));
            check("rr_active", int'(tx_active), (i < 4) ? 1 : 0);
            tick();
        end

        // Full FIFO: a further change stalls until a pop makes room in the same cycle
        ch_data = 32'h88776655;
        repeat (4) tick();
        ch_data[7:0] = 8'h99;
        repeat (3) begin
            tick();
            check("full_level", int'(fifo_level), 4);
        end
        tx_done = 1'b1; tick();
        tx_done = 1'b0;
        check("full_pushpop_level", int'(fifo_level), 4);
        check("full_pushpop_grant", int'(grant_ch), 0);
        check("full_pushpop_bits", int'(tx_bits), 8'h55);
        drain();
        check("full_drained", int'(fifo_level), 0);

        // Pause blocks the grant; release queues it one cycle later
        pause = 1'b1; ch_data[15:8] = 8'h5A;
        repeat (3) begin
            tick();
            check("pause_level", int'(fifo_level), 0);
        end
        pause = 1'b0; tick();
        check("unpause_level", int'(fifo_level), 1);
        check("unpause_grant", int'(grant_ch), 1);
        tx_done = 1'b1; tick();
        tx_done = 1'b0;
        check("unpause_bits", int'(tx_bits), 8'h5A);
        check("unpause_last", int'(last_sent), 8'h5A);
        drain();

        // Static channel: sent once, or periodically with the refresh build
        ch_en = 4'b0001; ch_data[7:0] = 8'h21;
        repeat (40) tick();
`ifdef UART_TX_SCHED_REFRESH_EN
        check("refresh_resent", (fifo_level >= 3'd2) ? 1 : 0, 1);
`else
        check("static_once", int'(fifo_level), 1);
`endif
        drain();

        // Reset with entries queued and a same-cycle tx_done
        ch_en = 4'hF; ch_data = 32'h0D0C0B0A;
        repeat (3) tick();
        check("mid_level", int'(fifo_level), 3);
        reset = 1'b1; tx_done = 1'b1; tick();
        check("mid_rst_level", int'(fifo_level), 0);
        check("mid_rst_bits", int'(tx_bits), 8'h00);
        check("mid_rst_active", int'(tx_active), 0);
        reset = 1'b0; tx_done = 1'b0; tick();
        check("mid_resend", int'(fifo_level), 1);
        drain();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) ch_data[8*c +: 8] = 8'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 31) == 0) ch_en = 4'($urandom);
            pause   = ($urandom_range(0, 5) == 0);
            tx_done = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; tx_done = 1'b0; pause = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
